// File: rtl/led_matrix_scanner_pkg.sv
// led_matrix_pkg: shared constants and types for the LED matrix scanner.
// Provides the default board geometry, the frame type and the scan FSM states.
package led_matrix_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        BLANK
    } scan_state_t;

endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: frame handshake from the generation engine.
// master: drives red_in/grn_in/frame_valid; slave: drives frame_ready.
interface led_matrix_scanner_if #(
    parameter int ROWS = 16,
    parameter int COLS = 16
);
    import led_matrix_pkg::*;

    logic [ROWS-1:0][COLS-1:0] red_in;
    logic [ROWS-1:0][COLS-1:0] grn_in;
    logic                      frame_valid;
    logic                      frame_ready;

    modport master (
        output red_in,
        output grn_in,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  red_in,
        input  grn_in,
        input  frame_valid,
        output frame_ready
    );

endinterface

// File: rtl/led_matrix_scanner_timer.sv
// scan_timer: up-counter cleared by load, with a terminal-count flag.
// Ports: CLOCK_50, reset, load (clear to 0), term (terminal value), tc.
module scan_timer
#(
    parameter int WIDTH = 11
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);
    import led_matrix_pkg::*;

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (reset || load) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered row scanner for a bicolour LED matrix.
// Ports: CLOCK_50, reset, bus (frame handshake), row_n, col_red, col_grn,
// frame_done (one-cycle pulse when row 0 is redriven after a full scan).
module led_matrix_scanner
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DWELL_CYCLES = 2048,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    led_matrix_scanner_if.slave bus,
    output logic [ROWS-1:0]     row_n,
    output logic [COLS-1:0]     col_red,
    output logic [COLS-1:0]     col_grn,
    output logic                frame_done
);
    import led_matrix_pkg::*;

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                        : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [TW-1:0] DWELL_T = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_T = TW'(BLANK_CYCLES - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    logic [ROWS-1:0][COLS-1:0] shd_red, shd_grn;
    logic [ROWS-1:0][COLS-1:0] act_red, act_grn;
    logic                      pending;
    logic [RW-1:0]             row, row_nx;
    scan_state_t               state, state_nx;

    logic                      accept, swap, wrap, wrap_q;
    logic                      tmr_load, tmr_tc;
    logic [TW-1:0]             tmr_term;

    logic [ROWS-1:0]           row_n_d;
    logic [COLS-1:0]           col_red_d, col_grn_d;

    assign bus.frame_ready = !pending;
    assign accept          = bus.frame_valid && !pending;

    scan_timer #(
        .WIDTH (TW)
    ) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .load     (tmr_load),
        .term     (tmr_term),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nx = state;
        row_nx   = row;
        swap     = 1'b0;
        wrap     = 1'b0;
        tmr_load = 1'b0;
        tmr_term = DWELL_T;
        unique case (state)
            IDLE: begin
                tmr_load = 1'b1;
                if (pending) begin
                    swap     = 1'b1;
                    state_nx = DRIVE;
                    row_nx   = '0;
                end
            end
            DRIVE: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    state_nx = BLANK;
                end
            end
            BLANK: begin
                tmr_term = BLANK_T;
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    state_nx = DRIVE;
                    if (row == ROW_MAX) begin
                        // Frame boundary: the only point the active buffer
                        // may change, so a scan never mixes two frames.
                        row_nx = '0;
                        wrap   = 1'b1;
                        swap   = pending;
                    end else begin
                        row_nx = row + RW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        row_n_d   = '1;
        col_red_d = '0;
        col_grn_d = '0;
        if (state == DRIVE) begin
            row_n_d[row] = 1'b0;
            col_red_d    = act_red[row];
            col_grn_d    = act_grn[row];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            pending    <= 1'b0;
            shd_red    <= '0;
            shd_grn    <= '0;
            act_red    <= '0;
            act_grn    <= '0;
            wrap_q     <= 1'b0;
            row_n      <= '1;
            col_red    <= '0;
            col_grn    <= '0;
            frame_done <= 1'b0;
        end else begin
            state  <= state_nx;
            row    <= row_nx;
            wrap_q <= wrap;
            // Outputs lag the state by one clock, so the pulse is delayed
            // once more to line up with the visible row-0 drive.
            frame_done <= wrap_q;
            if (accept) begin
                shd_red <= bus.red_in;
                shd_grn <= bus.grn_in;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
            if (swap) begin
                act_red <= shd_red;
                act_grn <= shd_grn;
            end
            row_n   <= row_n_d;
            col_red <= col_red_d;
            col_grn <= col_grn_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed self-checking bench for led_matrix_scanner.
// Runs reset, first frame, full scan, back-pressure, boundary race, reset.
module tb_led_matrix_scanner;
    import led_matrix_pkg::*;

    localparam int DW = 4;
    localparam int BL = 2;
    localparam int RP = DW + BL;
    localparam int FP = 16 * RP;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] row_n, col_red, col_grn;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int k = 0;

    frame_t fa_r, fa_g, fb_r, fb_g, fc_r, fc_g;
    frame_t fd_r, fd_g, fe_r, fe_g, ff_r, ff_g;

    led_matrix_scanner_if #(.ROWS(16), .COLS(16)) bus ();

    led_matrix_scanner #(
        .ROWS         (16),
        .COLS         (16),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .bus        (bus.slave),
        .row_n      (row_n),
        .col_red    (col_red),
        .col_grn    (col_grn),
        .frame_done (frame_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic frame_t mk(input logic [15:0] s);
        frame_t f;
        for (int r = 0; r < 16; r++) f[r] = s ^ 16'(16'h1111 * r);
        return f;
    endfunction

    // Expected {row_n, col_red, col_grn, frame_done} kk cycles after row 0
    // of a scan first became visible.
    function automatic logic [48:0] e_out(input frame_t fr, input frame_t fg,
                                          input int kk);
        int p;
        int r;
        logic [48:0] v;
        p = kk % FP;
        r = p / RP;
        if ((p % RP) < DW) v = {~(16'h1 << r), fr[r], fg[r], 1'b0};
        else v = {16'hFFFF, 32'h0, 1'b0};
        if (p == 0 && kk > 0) v[0] = 1'b1;
        return v;
    endfunction

    task automatic put(input frame_t r, input frame_t g);
        bus.red_in = r;
        bus.grn_in = g;
        bus.frame_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [49:0] obs;
        put(fe_r, fe_g);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        obs = {row_n, col_red, col_grn, frame_done, bus.frame_ready};
        tests++;
        if (obs !== {16'hFFFF, 32'h0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_vals got %h want %h", obs,
                     {16'hFFFF, 32'h0, 1'b0, 1'b1});
        end
        reset = 1'b0;
        bus.frame_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            obs = {row_n, col_red, col_grn, frame_done, bus.frame_ready};
            tests++;
            if (obs !== {16'hFFFF, 32'h0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset_no_accept i=%0d got %h want %h", i, obs,
                         {16'hFFFF, 32'h0, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_first_frame();
        logic [48:0] obs, want;
        put(fa_r, fa_g);
        @(negedge CLOCK_50);
        bus.frame_valid = 1'b0;
        tests++;
        if (bus.frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL first_pending ready=%b want 0", bus.frame_ready);
        end
        @(negedge CLOCK_50);
        tests++;
        if ({bus.frame_ready, row_n} !== {1'b1, 16'hFFFF}) begin
            fails++;
            $display("FAIL first_swap got ready=%b row_n=%h want 1 FFFF",
                     bus.frame_ready, row_n);
        end
        k = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            k++;
            obs = {row_n, col_red, col_grn, frame_done};
            want = (i < 4) ? {16'hFFFE, 16'h8001, 16'h0F0F, 1'b0}
                           : {16'hFFFF, 32'h0, 1'b0};
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL first_row0 k=%0d got %h want %h", k, obs, want);
            end
        end
    endtask

    task automatic test_full_scan();
        int pulses;
        int multi;
        logic [48:0] obs, want;
        pulses = 0;
        multi = 0;
        while (k < FP + 5) begin
            @(negedge CLOCK_50);
            k++;
            obs = {row_n, col_red, col_grn, frame_done};
            want = e_out(fa_r, fa_g, k);
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL full_scan k=%0d got %h want %h", k, obs, want);
            end
            if (frame_done) pulses++;
            if ($countones(~row_n) > 1) multi++;
        end
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL done_count got %0d want 1", pulses);
        end
        tests++;
        if (multi !== 0) begin
            fails++;
            $display("FAIL two_rows got %0d want 0", multi);
        end
    endtask

    task automatic test_back_pressure();
        logic [48:0] obs, want;
        logic rdy;
        put(fb_r, fb_g);
        while (k < 196) begin
            @(negedge CLOCK_50);
            k++;
            obs = {row_n, col_red, col_grn, frame_done};
            want = (k < 192) ? e_out(fa_r, fa_g, k) : e_out(fb_r, fb_g, k);
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL bp_scan k=%0d got %h want %h", k, obs, want);
            end
            rdy = (k == 191);
            tests++;
            if (bus.frame_ready !== rdy) begin
                fails++;
                $display("FAIL bp_ready k=%0d got %b want %b", k,
                         bus.frame_ready, rdy);
            end
            if (k == 102) put(fc_r, fc_g);
            if (k == 192) bus.frame_valid = 1'b0;
        end
    endtask

    task automatic test_boundary_race();
        logic [48:0] obs, want;
        logic rdy;
        while (k < 491) begin
            @(negedge CLOCK_50);
            k++;
            obs = {row_n, col_red, col_grn, frame_done};
            if (k < 288) want = e_out(fb_r, fb_g, k);
            else if (k < 480) want = e_out(fc_r, fc_g, k);
            else want = e_out(fd_r, fd_g, k);
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL race_scan k=%0d got %h want %h", k, obs, want);
            end
            rdy = (k < 287) ? 1'b0 : (k < 383) ? 1'b1 : (k < 479) ? 1'b0 : 1'b1;
            tests++;
            if (bus.frame_ready !== rdy) begin
                fails++;
                $display("FAIL race_ready k=%0d got %b want %b", k,
                         bus.frame_ready, rdy);
            end
            if (k == 382) put(fd_r, fd_g);
            if (k == 383) bus.frame_valid = 1'b0;
        end
    endtask

    task automatic test_mid_scan_reset();
        logic [48:0] obs, want;
        logic [16:0] idl;
        while (k < 522) begin
            @(negedge CLOCK_50);
            k++;
            obs = {row_n, col_red, col_grn, frame_done};
            want = e_out(fd_r, fd_g, k);
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL pre_reset k=%0d got %h want %h", k, obs, want);
            end
            if (k == 495) put(fe_r, fe_g);
            if (k == 496) bus.frame_valid = 1'b0;
        end
        tests++;
        if (row_n !== 16'hFF7F || bus.frame_ready !== 1'b0) begin
            fails++;
            $display("FAIL row7_pending got row_n=%h ready=%b want FF7F 0",
                     row_n, bus.frame_ready);
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        obs = {row_n, col_red, col_grn, frame_done};
        tests++;
        if ({obs, bus.frame_ready} !== {16'hFFFF, 32'h0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL mid_reset got %h ready=%b want FFFF..0 ready=1",
                     obs, bus.frame_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            idl = {row_n, bus.frame_ready};
            tests++;
            if (idl !== {16'hFFFF, 1'b1}) begin
                fails++;
                $display("FAIL idle_hold i=%0d got %h want %h", i, idl,
                         {16'hFFFF, 1'b1});
            end
        end
        put(ff_r, ff_g);
        @(negedge CLOCK_50);
        bus.frame_valid = 1'b0;
        @(negedge CLOCK_50);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            obs = {row_n, col_red, col_grn, frame_done};
            want = (i < 4) ? {16'hFFFE, 16'h4002, 16'h2004, 1'b0}
                           : {16'hFFFF, 32'h0, 1'b0};
            tests++;
            if (obs !== want) begin
                fails++;
                $display("FAIL post_reset i=%0d got %h want %h", i, obs, want);
            end
        end
    endtask

    initial begin
        fa_r = mk(16'h8001);
        fa_g = mk(16'h0F0F);
        fb_r = mk(16'hA5C3);
        fb_g = mk(16'h3C5A);
        fc_r = mk(16'h1234);
        fc_g = mk(16'hFEDC);
        fd_r = mk(16'h7E18);
        fd_g = mk(16'h0660);
        fe_r = mk(16'hDEAD);
        fe_g = mk(16'hBEEF);
        ff_r = mk(16'h4002);
        ff_g = mk(16'h2004);
        bus.red_in = '0;
        bus.grn_in = '0;
        bus.frame_valid = 1'b0;
        test_reset();
        test_first_frame();
        test_full_scan();
        test_back_pressure();
        test_boundary_race();
        test_mid_scan_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
